exe_stage_mc: RTL and testbench

Parametrised execute stage: selects operands, runs single-cycle ALU ops or a multi-cycle iterative divide, and holds the result in one output register with a full valid/ready handshake. Sits between the decode and memory stages. Adds synchronous flush and back-to-back throughput, unlike the previous single-cycle stage.

---
 rtl/exe_stage_mc_pkg.sv | 38 +++
 rtl/exe_iter_div.sv | 83 ++++++++
 rtl/exe_stage_mc.sv | 139 +++++++++++++
 tb/tb_exe_stage_mc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_mc_pkg.sv
// Shared types for the multi-cycle execute stage: opcodes, operand selects, FSM states.
package exe_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLT  = 4'd2,
        OP_SLTU = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOR  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11,
        OP_DIV  = 4'd12,
        OP_DIVU = 4'd13,
        OP_REM  = 4'd14,
        OP_REMU = 4'd15
    } exe_op_e;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FULL,
        ST_BUSY
    } exe_state_e;

    // Divide family occupies the top four opcodes; bit0 = unsigned, bit1 = remainder.
    function automatic logic is_div_op(input exe_op_e op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/exe_iter_div.sv
// Restoring radix-2 divider: one quotient bit per cycle on magnitudes, sign fixed up on the last step.
module exe_iter_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            signed_i,
    input  logic            want_rem_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CW = $clog2(XLEN);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dsr_q, dvd_q;
    logic            negq_q, negr_q, dz_q, want_rem_q;

    logic            a_neg, b_neg;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] rem_d, quo_d, q_fix, r_fix;

    assign a_neg = signed_i & dividend_i[XLEN-1];
    assign b_neg = signed_i & divisor_i[XLEN-1];

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
        rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
        q_fix   = dz_q ? '1    : (negq_q ? -quo_d : quo_d);
        r_fix   = dz_q ? dvd_q : (negr_q ? -rem_d : rem_d);
    end

    // The result is taken from the final iteration's combinational value so the
    // owner can capture it on the same edge that retires the last quotient bit.
    assign done_o   = busy_q && (cnt_q == CW'(XLEN - 1));
    assign result_o = want_rem_q ? r_fix : q_fix;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            dvd_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            dz_q       <= 1'b0;
            want_rem_q <= 1'b0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= a_neg ? -dividend_i : dividend_i;
            dsr_q      <= b_neg ? -divisor_i : divisor_i;
            dvd_q      <= dividend_i;
            negq_q     <= a_neg ^ b_neg;
            negr_q     <= a_neg;
            dz_q       <= (divisor_i == '0);
            want_rem_q <= want_rem_i;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: operand select, single-cycle ALU or iterative divide, one registered output slot with valid/ready.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 left_valid,
    output logic                 left_ready,
    input  logic [3:0]           id_op,
    input  logic [1:0]           sel_src1,
    input  logic [1:0]           sel_src2,
    input  logic [XLEN-1:0]      id_reg1,
    input  logic [XLEN-1:0]      id_reg2,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_inst,
    input  logic                 id_wreg_en,
    input  logic [REG_IDX_W-1:0] id_wreg_index,
    output logic                 right_valid,
    input  logic                 right_ready,
    output logic [XLEN-1:0]      ex_result,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_inst,
    output logic [XLEN-1:0]      ex_src2,
    output logic                 ex_wreg_en,
    output logic [REG_IDX_W-1:0] ex_wreg_index
);

    localparam int unsigned SHW = $clog2(XLEN);

    exe_state_e           state_q;
    logic [XLEN-1:0]      ex_result_q, ex_pc_q, ex_inst_q, ex_src2_q;
    logic                 ex_wreg_en_q;
    logic [REG_IDX_W-1:0] ex_wreg_index_q;

    exe_op_e         op;
    logic [XLEN-1:0] src1, src2, alu_res, div_res;
    logic            is_div, fire, div_done;

    function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] r,
                                             input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
        return sel[1] ? pc : (sel[0] ? imm : r);
    endfunction

    assign op     = exe_op_e'(id_op);
    assign src1   = pick(sel_src1, id_reg1, id_imm, id_pc);
    assign src2   = pick(sel_src2, id_reg2, id_imm, id_pc);
    assign is_div = is_div_op(op);

    assign left_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_FULL) & right_ready));
    assign fire       = left_valid & left_ready;

    always_comb begin
        alu_res = src2;
        case (op)
            OP_ADD:  alu_res = src1 + src2;
            OP_SUB:  alu_res = src1 - src2;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
            OP_AND:  alu_res = src1 & src2;
            OP_OR:   alu_res = src1 | src2;
            OP_XOR:  alu_res = src1 ^ src2;
            OP_NOR:  alu_res = ~(src1 | src2);
            OP_SLL:  alu_res = src1 << src2[SHW-1:0];
            OP_SRL:  alu_res = src1 >> src2[SHW-1:0];
            OP_SRA:  alu_res = $signed(src1) >>> src2[SHW-1:0];
            default: alu_res = src2;
        endcase
    end

    exe_iter_div #(.XLEN(XLEN)) u_div (
        .clk_i      (clk),
        .rst_i      (reset),
        .start_i    (fire & is_div),
        .abort_i    (flush),
        .signed_i   (~id_op[0]),
        .want_rem_i (id_op[1]),
        .dividend_i (src1),
        .divisor_i  (src2),
        .done_o     (div_done),
        .result_o   (div_res)
    );

    // Divide metadata goes straight into the output slot at issue; only the
    // result arrives later. The slot is invalid while BUSY, so nothing observes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            ex_result_q     <= '0;
            ex_pc_q         <= '0;
            ex_inst_q       <= '0;
            ex_src2_q       <= '0;
            ex_wreg_en_q    <= 1'b0;
            ex_wreg_index_q <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FULL: begin
                    if (fire) begin
                        ex_pc_q         <= id_pc;
                        ex_inst_q       <= id_inst;
                        ex_src2_q       <= src2;
                        ex_wreg_en_q    <= id_wreg_en;
                        ex_wreg_index_q <= id_wreg_index;
                        if (is_div) begin
                            state_q <= ST_BUSY;
                        end else begin
                            ex_result_q <= alu_res;
                            state_q     <= ST_FULL;
                        end
                    end else if (state_q == ST_FULL && right_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (div_done) begin
                        ex_result_q <= div_res;
                        state_q     <= ST_FULL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign right_valid   = (state_q == ST_FULL);
    assign ex_result     = ex_result_q;
    assign ex_pc         = ex_pc_q;
    assign ex_inst       = ex_inst_q;
    assign ex_src2       = ex_src2_q;
    assign ex_wreg_en    = ex_wreg_en_q;
    assign ex_wreg_index = ex_wreg_index_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: vector table, hand-written handshake/flush/reset sequences, random ops vs a reference model.
module tb_exe_stage_mc;
    import exe_pkg::*;

    logic        clk, reset, flush, left_valid, left_ready, right_valid, right_ready;
    logic [3:0]  id_op;
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] id_reg1, id_reg2, id_imm, id_pc, id_inst;
    logic        id_wreg_en, ex_wreg_en;
    logic [4:0]  id_wreg_index, ex_wreg_index;
    logic [31:0] ex_result, ex_pc, ex_inst, ex_src2;

    int errors = 0;
    int checks = 0;

    exe_stage_mc #(.XLEN(32), .REG_IDX_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .left_valid(left_valid), .left_ready(left_ready),
        .id_op(id_op), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm), .id_pc(id_pc), .id_inst(id_inst),
        .id_wreg_en(id_wreg_en), .id_wreg_index(id_wreg_index),
        .right_valid(right_valid), .right_ready(right_ready),
        .ex_result(ex_result), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_src2(ex_src2),
        .ex_wreg_en(ex_wreg_en), .ex_wreg_index(ex_wreg_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] imm, input logic [31:0] pc);
        if (s == 2'b10 || s == 2'b11) return pc;
        if (s == 2'b01) return imm;
        return r;
    endfunction

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        int unsigned sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return 32'(sa >>> sh);
            OP_LUI:  return b;
            OP_DIV:  begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [31:0] pc);
        id_op = op; sel_src1 = s1; sel_src2 = s2;
        id_reg1 = r1; id_reg2 = r2; id_imm = imm; id_pc = pc;
    endtask

    // Issue one op from IDLE/FULL with right_ready=1 and check latency and payload.
    task automatic run_op(input logic [3:0] op, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [31:0] exp_res, input string nm);
        int lat;
        int exp_lat;
        logic [31:0] inst;
        logic [4:0]  widx;
        logic        wen;
        inst = $urandom;
        widx = 5'($urandom);
        wen  = inst[7];
        exp_lat = (op >= 4'd12) ? 33 : 1;
        @(negedge clk);
        drive(op, s1, s2, r1, r2, imm, pc);
        id_inst = inst; id_wreg_en = wen; id_wreg_index = widx;
        left_valid = 1'b1; right_ready = 1'b1;
        #1 check({nm, "_lready"}, 32'(left_ready), 32'd1);
        @(posedge clk); #1;
        left_valid = 1'b0;
        lat = 1;
        while (!right_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_result"}, ex_result, exp_res);
        check({nm, "_pc"}, ex_pc, pc);
        check({nm, "_inst"}, ex_inst, inst);
        check({nm, "_src2"}, ex_src2, pick(s2, r2, imm, pc));
        check({nm, "_wreg"}, {26'd0, wen, widx}, {26'd0, ex_wreg_en, ex_wreg_index});
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  s1, s2;
        logic [31:0] r1, r2, imm, pc;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[$];
    int   seen;

    initial begin
        reset = 1'b1; flush = 1'b0; left_valid = 1'b0; right_ready = 1'b0;
        drive(4'd0, 2'b00, 2'b00, '0, '0, '0, '0);
        id_inst = '0; id_wreg_en = 1'b0; id_wreg_index = '0;

        vecs.push_back('{OP_ADD,  SEL_REG, SEL_REG, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h0000_0000, "add_wrap"});
        vecs.push_back('{OP_SUB,  SEL_REG, SEL_REG, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE, "sub_neg"});
        vecs.push_back('{OP_SLT,  SEL_REG, SEL_REG, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1, "slt"});
        vecs.push_back('{OP_SLTU, SEL_REG, SEL_REG, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, "sltu"});
        vecs.push_back('{OP_AND,  SEL_REG, SEL_REG, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 32'hF000_F000, "and"});
        vecs.push_back('{OP_OR,   SEL_REG, SEL_REG, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 32'd0, 32'hF0F0_0F0F, "or"});
        vecs.push_back('{OP_XOR,  SEL_REG, SEL_REG, 32'hFFFF_0000, 32'hFF00_FF00, 32'd0, 32'd0, 32'h00FF_FF00, "xor"});
        vecs.push_back('{OP_NOR,  SEL_REG, SEL_REG, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, "nor"});
        vecs.push_back('{OP_SLL,  SEL_REG, SEL_REG, 32'd1, 32'h0000_003F, 32'd0, 32'd0, 32'h8000_0000, "sll_mask"});
        vecs.push_back('{OP_SRL,  SEL_REG, SEL_REG, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'h0800_0000, "srl"});
        vecs.push_back('{OP_SRA,  SEL_REG, SEL_REG, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'hF800_0000, "sra"});
        vecs.push_back('{OP_LUI,  SEL_REG, SEL_IMM, 32'd9, 32'd9, 32'h1234_5000, 32'd0, 32'h1234_5000, "lui"});
        vecs.push_back('{OP_ADD,  SEL_PC,  SEL_IMM, 32'd9, 32'd9, 32'd4, 32'h0000_1000, 32'h0000_1004, "add_pc_imm"});
        vecs.push_back('{OP_ADD,  2'b11,   SEL_REG, 32'd9, 32'd8, 32'd77, 32'h0000_2000, 32'h0000_2008, "sel11_pc"});
        vecs.push_back('{OP_DIV,  SEL_REG, SEL_REG, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, "div_ovf"});
        vecs.push_back('{OP_REM,  SEL_REG, SEL_REG, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, "rem_ovf"});
        vecs.push_back('{OP_DIVU, SEL_REG, SEL_REG, 32'd7, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, "divu_zero"});
        vecs.push_back('{OP_REMU, SEL_REG, SEL_REG, 32'd7, 32'd0, 32'd0, 32'd0, 32'd7, "remu_zero"});
        vecs.push_back('{OP_DIV,  SEL_REG, SEL_REG, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, "div_zero_neg"});
        vecs.push_back('{OP_REM,  SEL_REG, SEL_REG, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFF9, "rem_zero_neg"});
        vecs.push_back('{OP_DIV,  SEL_REG, SEL_REG, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFD, "div_neg"});
        vecs.push_back('{OP_REM,  SEL_REG, SEL_REG, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, "rem_neg"});
        vecs.push_back('{OP_DIVU, SEL_REG, SEL_REG, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, "divu_max"});

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rvalid", 32'(right_valid), 32'd0);
        check("rst_result", ex_result, 32'd0);
        check("rst_pc", ex_pc, 32'd0);
        check("rst_lready", 32'(left_ready), 32'd1);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].r1, vecs[i].r2,
                   vecs[i].imm, vecs[i].pc, vecs[i].exp, vecs[i].nm);

        // Back-to-back ADD, SUB, SRA with no bubble
        @(negedge clk);
        drive(OP_ADD, SEL_REG, SEL_REG, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        left_valid = 1'b1; right_ready = 1'b1;
        @(negedge clk);
        check("b2b_add_valid", 32'(right_valid), 32'd1);
        check("b2b_add", ex_result, 32'd0);
        check("b2b_lready1", 32'(left_ready), 32'd1);
        drive(OP_SUB, SEL_REG, SEL_REG, 32'd3, 32'd5, 32'd0, 32'd0);
        @(negedge clk);
        check("b2b_sub", ex_result, 32'hFFFF_FFFE);
        check("b2b_lready2", 32'(left_ready), 32'd1);
        drive(OP_SRA, SEL_REG, SEL_REG, 32'h8000_0000, 32'd31, 32'd0, 32'd0);
        @(negedge clk);
        check("b2b_sra", ex_result, 32'hFFFF_FFFF);
        check("b2b_sra_valid", 32'(right_valid), 32'd1);
        left_valid = 1'b0;
        @(negedge clk);
        check("b2b_drain", 32'(right_valid), 32'd0);

        // Back-pressure holds payload; release with a waiting op swaps on one edge
        drive(OP_ADD, SEL_REG, SEL_REG, 32'd10, 32'd20, 32'd0, 32'd0);
        left_valid = 1'b1; right_ready = 1'b0;
        @(negedge clk);
        check("bp_first", ex_result, 32'd30);
        drive(OP_XOR, SEL_REG, SEL_REG, 32'h0000_000A, 32'h0000_0005, 32'd0, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(right_valid), 32'd1);
            check("bp_hold_result", ex_result, 32'd30);
            check("bp_hold_lready", 32'(left_ready), 32'd0);
        end
        right_ready = 1'b1;
        #1 check("bp_release_lready", 32'(left_ready), 32'd1);
        @(negedge clk);
        check("bp_swap_valid", 32'(right_valid), 32'd1);
        check("bp_swap_result", ex_result, 32'h0000_000F);
        left_valid = 1'b0;
        @(negedge clk);

        // Flush at cycle 10 of a divide
        drive(OP_DIV, SEL_REG, SEL_REG, 32'd100, 32'd7, 32'd0, 32'd0);
        left_valid = 1'b1;
        @(posedge clk); #1;
        left_valid = 1'b0;
        check("div_busy_lready", 32'(left_ready), 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush_lready_low", 32'(left_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_rvalid", 32'(right_valid), 32'd0);
        check("flush_lready", 32'(left_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (right_valid) seen++;
        end
        check("flush_no_result", 32'(seen), 32'd0);
        run_op(OP_DIVU, SEL_REG, SEL_REG, 32'd100, 32'd7, 32'd0, 32'd0, 32'd14, "div_after_flush");

        // Flush with left_valid: nothing accepted
        @(negedge clk);
        drive(OP_ADD, SEL_REG, SEL_REG, 32'd1, 32'd1, 32'd0, 32'd0);
        left_valid = 1'b1; flush = 1'b1;
        #1 check("flush_lv_lready", 32'(left_ready), 32'd0);
        @(negedge clk);
        left_valid = 1'b0; flush = 1'b0;
        check("flush_lv_rvalid", 32'(right_valid), 32'd0);

        // Flush coinciding with divide completion discards the result
        @(negedge clk);
        drive(OP_DIVU, SEL_REG, SEL_REG, 32'd50, 32'd5, 32'd0, 32'd0);
        left_valid = 1'b1;
        @(posedge clk); #1;
        left_valid = 1'b0;
        repeat (31) @(posedge clk);
        @(negedge clk);
        check("flush_done_pre", 32'(right_valid), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_rvalid", 32'(right_valid), 32'd0);
        @(negedge clk);
        check("flush_done_rvalid2", 32'(right_valid), 32'd0);

        // Reset mid-divide clears outputs without waiting for a clock
        run_op(OP_ADD, SEL_REG, SEL_REG, 32'd40, 32'd2, 32'd0, 32'h0000_0444, 32'd42, "pre_rst");
        @(negedge clk);
        drive(OP_DIV, SEL_REG, SEL_REG, 32'd1000, 32'd3, 32'd0, 32'hABCD_0000);
        left_valid = 1'b1;
        @(posedge clk); #1;
        left_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_rvalid", 32'(right_valid), 32'd0);
        check("rst_mid_result", ex_result, 32'd0);
        check("rst_mid_pc", ex_pc, 32'd0);
        check("rst_mid_lready", 32'(left_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_op(OP_ADD, SEL_REG, SEL_REG, 32'd1, 32'd2, 32'd0, 32'd0, 32'd3, "post_rst_add");
        run_op(OP_DIV, SEL_REG, SEL_REG, 32'd1000, 32'd3, 32'd0, 32'd0, 32'd333, "post_rst_div");

        // Random ops against the reference model
        for (int n = 0; n < 120; n++) begin
            logic [3:0]  op;
            logic [1:0]  s1, s2;
            logic [31:0] r1, r2, imm, pc, a, b;
            op = 4'($urandom_range(0, 15));
            s1 = 2'($urandom); s2 = 2'($urandom);
            r1 = $urandom; r2 = $urandom; imm = $urandom; pc = $urandom;
            case ($urandom_range(0, 5))
                0: r2 = 32'd0;
                1: r2 = 32'hFFFF_FFFF;
                2: r2 = 32'($urandom_range(1, 40));
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) r1 = 32'h8000_0000;
            a = pick(s1, r1, imm, pc);
            b = pick(s2, r2, imm, pc);
            run_op(op, s1, s2, r1, r2, imm, pc, model(op, a, b), "rand");
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
